// File: rtl/obi_pkg.sv
// Shared OBI bus constants and the request bundle used by the arbiter.
package obi_pkg;

    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

    typedef struct packed {
        logic [OBI_AW-1:0]  addr;
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
import obi_pkg::*;

module obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // Overflow/underflow are blocked here so callers can stay simple.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = nxt(wr_q);
        if (do_pop)  rd_d = nxt(rd_q);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter with in-order response routing.
// Optional bus locking is enabled by defining OBI_ARB_LOCK_EN.
import obi_pkg::*;

module obi_rr_arbiter #(
    parameter int N_PORTS         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
`ifdef OBI_ARB_LOCK_EN
    input  logic [N_PORTS-1:0]        p_lock_i,
`endif
    input  logic [N_PORTS-1:0]        p_req_i,
    output logic [N_PORTS-1:0]        p_gnt_o,
    input  logic [OBI_AW*N_PORTS-1:0] p_addr_i,
    input  logic [N_PORTS-1:0]        p_we_i,
    input  logic [OBI_BEW*N_PORTS-1:0] p_be_i,
    input  logic [OBI_DW*N_PORTS-1:0] p_wdata_i,
    output logic [N_PORTS-1:0]        p_rvalid_o,
    output logic [OBI_DW-1:0]         p_rdata_o,
    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    output logic [OBI_AW-1:0]         s_addr_o,
    output logic                      s_we_o,
    output logic [OBI_BEW-1:0]        s_be_o,
    output logic [OBI_DW-1:0]         s_wdata_o,
    input  logic                      s_rvalid_i,
    input  logic [OBI_DW-1:0]         s_rdata_i
);

    localparam int IDW = $clog2(N_PORTS);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     sel_q, sel_d;
    logic               hold_q, hold_d;
    logic [IDW-1:0]     sel, sel_rr, cand;
    logic               found;
    logic [N_PORTS-1:0] elig;
    logic               hs, rsp, ptr_frozen;
    logic               fifo_full, fifo_empty;
    logic [IDW-1:0]     fifo_head;
    obi_req_t           req_sel;

    function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] v);
        if (v == IDW'(N_PORTS - 1)) return '0;
        return v + IDW'(1);
    endfunction

`ifdef OBI_ARB_LOCK_EN
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    always_comb begin
        elig = p_req_i;
        if (lock_q) begin
            elig = '0;
            elig[lock_id_q] = p_req_i[lock_id_q];
        end
    end

    assign ptr_frozen = lock_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (hs) begin
            if (lock_q) begin
                if (!p_lock_i[sel]) lock_d = 1'b0;
            end else if (p_lock_i[sel]) begin
                lock_d    = 1'b1;
                lock_id_d = sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign elig       = p_req_i;
    assign ptr_frozen = 1'b0;
`endif

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        sel_rr = ptr_q;
        found  = 1'b0;
        cand   = ptr_q;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && elig[cand]) begin
                sel_rr = cand;
                found  = 1'b1;
            end
            cand = inc(cand);
        end
    end

    assign sel     = hold_q ? sel_q : sel_rr;
    assign s_req_o = rst_ni && (|elig) && !fifo_full;
    assign hs      = s_req_o && s_gnt_i;
    assign rsp     = rst_ni && s_rvalid_i && !fifo_empty;

    always_comb begin
        req_sel.addr  = p_addr_i[sel*OBI_AW +: OBI_AW];
        req_sel.we    = p_we_i[sel];
        req_sel.be    = p_be_i[sel*OBI_BEW +: OBI_BEW];
        req_sel.wdata = p_wdata_i[sel*OBI_DW +: OBI_DW];
    end

    assign s_addr_o  = req_sel.addr;
    assign s_we_o    = req_sel.we;
    assign s_be_o    = req_sel.be;
    assign s_wdata_o = req_sel.wdata;
    assign p_rdata_o = s_rdata_i;

    always_comb begin
        p_gnt_o    = '0;
        p_rvalid_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            p_gnt_o[k]    = hs && (sel == IDW'(k));
            p_rvalid_o[k] = rsp && (fifo_head == IDW'(k));
        end
    end

    // A stalled request freezes the selection until it is accepted.
    always_comb begin
        hold_d = hold_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        if (hs) begin
            hold_d = 1'b0;
            if (!ptr_frozen) ptr_d = inc(sel);
        end else if (s_req_o) begin
            hold_d = 1'b1;
            sel_d  = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            sel_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            hold_q <= hold_d;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .pop_i   (rsp),
        .data_i  (sel),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI secondary port between N_PORTS OBI primaries using round-robin arbitration.
- Tracks the requester ID of every granted transaction in an in-order ID FIFO, and routes each response (rvalid) back to the requester that issued it.
- Sits upstream of a single peripheral or an OBI CDC. Request and response paths are single-cycle pass-through, with no added register stage.

Parameters:
- N_PORTS, 2, number of primaries (>=2)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>=1)
- IDW, $clog2(N_PORTS), requester index width (derived localparam)

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  async active-low reset
- p_req_i  in  N_PORTS  per-primary request
- p_gnt_o  out  N_PORTS  per-primary grant
- p_addr_i  in  32*N_PORTS  packed addresses; port k occupies [32k+31:32k]
- p_we_i  in  N_PORTS  write enable
- p_be_i  in  4*N_PORTS  byte enables
- p_wdata_i  in  32*N_PORTS  write data
- p_rvalid_o  out  N_PORTS  per-primary response valid
- p_rdata_o  out  32  read data, broadcast to all primaries
- s_req_o  out  1  secondary request
- s_gnt_i  in  1  secondary grant
- s_addr_o  out  32  selected address
- s_we_o  out  1  selected write enable
- s_be_o  out  4  selected byte enables
- s_wdata_o  out  32  selected write data
- s_rvalid_i  in  1  secondary response valid
- s_rdata_i  in  32  secondary read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - ptr_q=0, hold_q=0, sel_q=0, FIFO empty.
  - While rst_ni=0, s_req_o, all p_gnt_o and all p_rvalid_o are forced to 0.
- Selection:
  - When hold_q=0: sel = first asserted p_req_i searching ptr_q, ptr_q+1, ... with wrap modulo N_PORTS.
  - When hold_q=1: sel = sel_q.
- s_req_o = (|p_req_i) && !fifo_full.
- s_addr_o, s_we_o, s_be_o and s_wdata_o are muxed from sel.
- Handshake:
  - hs = s_req_o && s_gnt_i.
  - p_gnt_o[sel] = hs; all other grants are 0.
  - Grant is combinational (zero cycles) from s_gnt_i.
- Stall hold (OBI stability):
  - If s_req_o && !s_gnt_i: hold_q<=1 and sel_q<=sel.
  - hold_q clears on hs.
  - While hold_q=1, a newly asserting requester must not change s_addr_o or the other selected fields.
- On hs:
  - Push sel into the ID FIFO.
  - ptr_q <= (sel+1) mod N_PORTS.
- Response:
  - On s_rvalid_i with FIFO non-empty: p_rvalid_o[head]=1 in the same cycle, then pop.
  - p_rdata_o = s_rdata_i at all times.
- Full FIFO (count==MAX_OUTSTANDING):
  - s_req_o=0, and no push occurs even if a pop happens in the same cycle.
  - hold_q cannot be 1 while the FIFO is full.
- Simultaneous hs and rvalid when not full: push and pop both occur, and count is unchanged.
- Spurious s_rvalid_i with FIFO empty: ignored, all p_rvalid_o=0, no state change.
- Reset mid-operation: outstanding IDs are discarded; responses arriving after reset release are treated as spurious.

Optional Feature:
- Macro: OBI_ARB_LOCK_EN.
- Defined:
  - Adds port p_lock_i in N_PORTS.
  - A handshake with p_lock_i[sel]=1 sets lock_q and stores the port in lock_id_q.
  - While lock_q=1, only lock_id_q is eligible, and ptr_q does not advance.
  - lock_q clears on a handshake from lock_id_q with p_lock_i=0.
  - lock_q resets to 0.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package obi_pkg:
  - OBI_AW=32, OBI_DW=32, OBI_BEW=4 constants.
  - obi_req_t struct (addr, we, be, wdata).
- Sub-module obi_id_fifo:
  - Parameters DEPTH and WIDTH.
  - Ports push/pop/full/empty/head.
  - Async active-low reset, counter-based, wrap-around pointers.

Test Plan:
- Port1 only: read 0x1000_0040, s_gnt_i=1 on the same cycle, s_rvalid_i 2 cycles later with rdata 0xDEAD_BEEF -> p_gnt_o=2'b10, p_rvalid_o=2'b10, p_rdata_o=0xDEAD_BEEF.
- Both ports request after reset, s_gnt_i always 1 -> grants 01, 10, 01 on consecutive cycles; rvalids return in the same order.
- Port1 selected with s_gnt_i low 3 cycles, port0 asserts on cycle 2 -> s_addr_o stays at port1's address; port1 is granted on cycle 4.
- MAX_OUTSTANDING=2: two grants with no rvalid -> s_req_o=0. One rvalid -> p_rvalid_o to the first requester, and s_req_o=1 on the next cycle.
- Reset asserted with 1 outstanding, released, then s_rvalid_i pulse -> p_rvalid_o=0; the next request goes to port0 (ptr_q=0).
- OBI_ARB_LOCK_EN: port1 handshakes with p_lock_i=1 while port0 also requests -> port1 gets the next 2 grants. Port1 handshakes with p_lock_i=0 -> port0 is granted next.
